nco_quadrature: RTL and testbench

- Parametrised numerically controlled oscillator producing signed cos and sin samples for the 1-bit AM transmitter's I/Q mixer.
- Successor to the fixed 16-entry registered cosine table.
- Adds a phase accumulator with a programmable tuning word and quarter-wave ROM folding to produce both quadrature outputs.
- Adds a pipelined valid strobe, clock-enable stalling and a synchronous phase clear.

---
 rtl/nco_quadrature.sv | 169 ++++++++++++++++
 tb/tb_nco_quadrature.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_quadrature.sv
// Quadrature NCO: phase accumulator + quarter-wave cosine ROM -> signed cos/sin samples.
// Latency: 3 edges from an enabled edge to out_valid with its sample (stage1 index, stage2 ROM, stage3 sign).
// Backpressure: en low stalls the accumulator and issues no sample; outputs hold until the next valid.
// Optional build macro NCO_PHASE_DITHER_EN adds LFSR phase dither ahead of index truncation.
module nco_quadrature #(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [PHASE_W-1:0]       freq_word,
  input  logic                     freq_load,
  input  logic                     phase_clr,
  output logic signed [DATA_W-1:0] cos_out,
  output logic signed [DATA_W-1:0] sin_out,
  output logic                     out_valid
);

  localparam int N  = 2 ** ADDR_W;
  localparam int NQ = N / 4;
  localparam int RW = ADDR_W - 2;

  // Quarter-wave sample: round(A*cos(2*pi*k/N)) with symmetric amplitude A = 2^(DATA_W-1)-1.
  // Only k in [0, N/4] is ever requested, so x stays in [0, pi/2] and the series converges fast.
  function automatic logic [DATA_W-1:0] qval(input int k);
    real x;
    real term;
    real sum;
    real amp;
    x    = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n <= 14; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    amp  = real'((2 ** (DATA_W - 1)) - 1);
    qval = DATA_W'($rtoi(amp * sum + 0.5));
  endfunction

  logic [DATA_W-1:0] rom [0:NQ];

  for (genvar g = 0; g <= NQ; g++) begin : g_rom
    assign rom[g] = qval(g);
  end

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] freq_reg;
  logic [PHASE_W-1:0] ph;
  logic [ADDR_W-1:0]  k_s1;
  logic [ADDR_W-2:0]  nidx;
  logic [1:0]         quad_s2;
  logic [DATA_W-1:0]  qa_s2;
  logic [DATA_W-1:0]  qb_s2;
  logic               v1;
  logic               v2;

`ifdef NCO_PHASE_DITHER_EN
  localparam int DITH_W = PHASE_W - ADDR_W;
  logic [15:0]        lfsr;
  logic [PHASE_W-1:0] dith;

  // Low LFSR bits, zero-extended when the truncated field is wider than the LFSR.
  always_comb begin
    dith = '0;
    for (int i = 0; i < DITH_W && i < 16; i++) begin
      dith[i] = lfsr[i];
    end
  end

  // Maximal 16-bit LFSR (x^16+x^14+x^13+x^11+1); only reset reseeds it, phase_clr does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (en) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign ph = acc + dith;
`else
  assign ph = acc;
`endif

  // Mirror index into the quarter table: N/4 - r, always within [1, N/4].
  assign nidx = (ADDR_W - 1)'(NQ) - {1'b0, k_s1[RW-1:0]};

  // Tuning word register and phase accumulator; clear wins over advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_reg <= '0;
      acc      <= '0;
    end else begin
      if (freq_load) begin
        freq_reg <= freq_word;
      end
      if (phase_clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc + freq_reg;
      end
    end
  end

  // Stage 1: latch the current sample's table index (pre-add, pre-clear phase).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_s1 <= '0;
    end else if (en) begin
      k_s1 <= ph[PHASE_W-1 -: ADDR_W];
    end
  end

  // Stage 2: both quarter-table reads registered, quadrant forwarded; always flows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quad_s2 <= '0;
      qa_s2   <= '0;
      qb_s2   <= '0;
    end else begin
      quad_s2 <= k_s1[ADDR_W-1 -: 2];
      qa_s2   <= rom[{1'b0, k_s1[RW-1:0]}];
      qb_s2   <= rom[nidx];
    end
  end

  // Valid strobe: en delayed through three registers, aligned with the data stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1        <= en;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  // Stage 3: quadrant sign/select into the outputs, updated only for a real sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cos_out <= '0;
      sin_out <= '0;
    end else if (v2) begin
      case (quad_s2)
        2'd0: begin
          cos_out <=  $signed(qa_s2);
          sin_out <=  $signed(qb_s2);
        end
        2'd1: begin
          cos_out <= -$signed(qb_s2);
          sin_out <=  $signed(qa_s2);
        end
        2'd2: begin
          cos_out <= -$signed(qa_s2);
          sin_out <= -$signed(qb_s2);
        end
        default: begin
          cos_out <=  $signed(qb_s2);
          sin_out <= -$signed(qa_s2);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_quadrature.sv
// Bench for nco_quadrature: posedge model pushes expected samples, negedge monitor pops and compares.
// Scenario tasks also check specific captured samples against fixed values.
// Inputs are driven right after each falling edge.
module tb_nco_quadrature;
  localparam int PW = 24;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int N  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic freq_load = 1'b0;
  logic phase_clr = 1'b0;
  logic [PW-1:0] freq_word = '0;
  logic signed [DW-1:0] cos_out;
  logic signed [DW-1:0] sin_out;
  logic out_valid;

  int total = 0;
  int bad = 0;

  typedef struct {
    int c;
    int s;
  } smp_t;

  smp_t exp_q[$];
  int   cap_c[$];
  int   cap_s[$];
  logic [PW-1:0] macc;
  logic [PW-1:0] mfreq;
  logic [2:0]    vpipe;
  int   last_c;
  int   last_s;
  int   npulse = 0;

  always #5 clk = ~clk;

  nco_quadrature #(.PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .freq_word(freq_word), .freq_load(freq_load),
    .phase_clr(phase_clr), .cos_out(cos_out), .sin_out(sin_out), .out_valid(out_valid)
  );

  function automatic int ref_cos(input int k);
    real v;
    v = 127.0 * $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(N));
    ref_cos = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int ref_sin(input int k);
    ref_sin = ref_cos((k + N - N / 4) % N);
  endfunction

  // Reference model of accumulator, tuning register and valid pipeline.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      macc = '0;
      mfreq = '0;
      vpipe = '0;
      exp_q.delete();
      last_c = 0;
      last_s = 0;
    end else begin
      vpipe = {vpipe[1:0], en};
      if (en) begin
        int k;
        smp_t e;
        k = int'(macc[PW-1 -: AW]);
        e.c = ref_cos(k);
        e.s = ref_sin(k);
        exp_q.push_back(e);
      end
      if (phase_clr) macc = '0;
      else if (en) macc = macc + mfreq;
      if (freq_load) mfreq = freq_word;
    end
  end

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (out_valid !== vpipe[2]) begin
        bad++;
        $display("FAIL valid_timing got=%b want=%b t=%0t", out_valid, vpipe[2], $time);
      end
      if (out_valid === 1'b1) begin
        npulse++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_sample got=(%0d,%0d) want=none", cos_out, sin_out);
        end else begin
          smp_t e;
          e = exp_q.pop_front();
          if (int'(cos_out) !== e.c || int'(sin_out) !== e.s) begin
            bad++;
            $display("FAIL sample got=(%0d,%0d) want=(%0d,%0d) t=%0t", cos_out, sin_out, e.c, e.s, $time);
          end
        end
        cap_c.push_back(int'(cos_out));
        cap_s.push_back(int'(sin_out));
        last_c = int'(cos_out);
        last_s = int'(sin_out);
      end else begin
        total++;
        if (int'(cos_out) !== last_c || int'(sin_out) !== last_s) begin
          bad++;
          $display("FAIL hold got=(%0d,%0d) want=(%0d,%0d)", cos_out, sin_out, last_c, last_s);
        end
      end
    end
  end

  task automatic drv(input logic e, input logic ld, input logic [PW-1:0] w, input logic clr);
    en = e;
    freq_load = ld;
    freq_word = w;
    phase_clr = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic clear_cap();
    cap_c.delete();
    cap_s.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || cos_out !== '0 || sin_out !== '0) begin
      bad++;
      $display("FAIL reset_state got=(%b,%h,%h) want=(0,00,00)", out_valid, cos_out, sin_out);
    end
    #1 rst_n = 1'b1;
    idle(2);
    total++;
    if (out_valid !== 1'b0 || cos_out !== '0 || sin_out !== '0) begin
      bad++;
      $display("FAIL post_reset_idle got=(%b,%h,%h) want=(0,00,00)", out_valid, cos_out, sin_out);
    end
  endtask

  task automatic test_quarter();
    int ec[4] = '{127, 0, -127, 0};
    int es[4] = '{0, 127, 0, -127};
    drv(1'b0, 1'b1, 24'h400000, 1'b0);
    clear_cap();
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 1'b0, '0, 1'b0);
      if (i < 3) begin
        total++;
        if (out_valid !== (i == 2)) begin
          bad++;
          $display("FAIL latency edge=%0d got=%b want=%b", i, out_valid, (i == 2));
        end
      end
    end
    idle(4);
    total++;
    if (cap_c.size() != 8) begin
      bad++;
      $display("FAIL quarter_count got=%0d want=8", cap_c.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (cap_c[i] != ec[i % 4] || cap_s[i] != es[i % 4]) begin
          bad++;
          $display("FAIL quarter[%0d] got=(%0d,%0d) want=(%0d,%0d)", i, cap_c[i], cap_s[i], ec[i % 4], es[i % 4]);
        end
      end
    end
    total++;
    if (sin_out !== 8'h81 || cos_out !== 8'h00) begin
      bad++;
      $display("FAIL min_code got=(%h,%h) want=(00,81)", cos_out, sin_out);
    end
  endtask

  task automatic test_step4();
    int ec[16] = '{127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49, 0, 49, 90, 117};
    drv(1'b0, 1'b1, 24'h100000, 1'b1);
    clear_cap();
    for (int i = 0; i < 16; i++) drv(1'b1, 1'b0, '0, 1'b0);
    idle(4);
    total++;
    if (cap_c.size() != 16) begin
      bad++;
      $display("FAIL step4_count got=%0d want=16", cap_c.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (cap_c[i] != ec[i] || cap_s[i] != ec[(i + 12) % 16]) begin
          bad++;
          $display("FAIL step4[%0d] got=(%0d,%0d) want=(%0d,%0d)", i, cap_c[i], cap_s[i], ec[i], ec[(i + 12) % 16]);
        end
      end
    end
  endtask

  task automatic test_step1();
    int n128;
    drv(1'b0, 1'b1, 24'h040000, 1'b1);
    clear_cap();
    for (int i = 0; i < 65; i++) drv(1'b1, 1'b0, '0, 1'b0);
    idle(4);
    total++;
    if (cap_c.size() != 65) begin
      bad++;
      $display("FAIL step1_count got=%0d want=65", cap_c.size());
    end else begin
      total++;
      if (cap_c[8] != 90 || cap_s[8] != 90) begin
        bad++;
        $display("FAIL step1[8] got=(%0d,%0d) want=(90,90)", cap_c[8], cap_s[8]);
      end
      total++;
      if (cap_c[16] != 0 || cap_s[16] != 127) begin
        bad++;
        $display("FAIL step1[16] got=(%0d,%0d) want=(0,127)", cap_c[16], cap_s[16]);
      end
      total++;
      if (cap_c[64] != 127 || cap_s[64] != 0) begin
        bad++;
        $display("FAIL step1_wrap got=(%0d,%0d) want=(127,0)", cap_c[64], cap_s[64]);
      end
      n128 = 0;
      for (int i = 0; i < 65; i++) if (cap_c[i] == -128 || cap_s[i] == -128) n128++;
      total++;
      if (n128 != 0) begin
        bad++;
        $display("FAIL no_neg128 got=%0d want=0", n128);
      end
    end
  endtask

  task automatic test_gap();
    drv(1'b0, 1'b1, 24'h400000, 1'b1);
    clear_cap();
    npulse = 0;
    drv(1'b1, 1'b0, '0, 1'b0);
    drv(1'b0, 1'b0, '0, 1'b0);
    drv(1'b0, 1'b0, '0, 1'b0);
    drv(1'b1, 1'b0, '0, 1'b0);
    idle(5);
    total++;
    if (npulse != 2 || cap_c.size() != 2) begin
      bad++;
      $display("FAIL gap_pulses got=%0d want=2", npulse);
    end else begin
      total++;
      if (cap_c[0] != 127 || cap_s[0] != 0 || cap_c[1] != 0 || cap_s[1] != 127) begin
        bad++;
        $display("FAIL gap_samples got=(%0d,%0d),(%0d,%0d) want=(127,0),(0,127)", cap_c[0], cap_s[0], cap_c[1], cap_s[1]);
      end
    end
  endtask

  task automatic test_clr();
    clear_cap();
    for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, '0, 1'b0);
    drv(1'b1, 1'b1, 24'h100000, 1'b1);
    for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, '0, 1'b0);
    idle(4);
    total++;
    if (cap_c.size() != 7) begin
      bad++;
      $display("FAIL clr_count got=%0d want=7", cap_c.size());
    end else begin
      total++;
      if (cap_c[3] != 0 || cap_s[3] != 127) begin
        bad++;
        $display("FAIL clr_old_phase got=(%0d,%0d) want=(0,127)", cap_c[3], cap_s[3]);
      end
      total++;
      if (cap_c[4] != 127 || cap_s[4] != 0) begin
        bad++;
        $display("FAIL clr_zero got=(%0d,%0d) want=(127,0)", cap_c[4], cap_s[4]);
      end
      total++;
      if (cap_c[5] != 117 || cap_s[5] != 49) begin
        bad++;
        $display("FAIL clr_newfreq got=(%0d,%0d) want=(117,49)", cap_c[5], cap_s[5]);
      end
    end
  endtask

  task automatic test_async_reset();
    drv(1'b0, 1'b1, 24'h400000, 1'b1);
    for (int i = 0; i < 5; i++) drv(1'b1, 1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    clear_cap();
    #1;
    total++;
    if (out_valid !== 1'b0 || cos_out !== '0 || sin_out !== '0) begin
      bad++;
      $display("FAIL async_reset got=(%b,%h,%h) want=(0,00,00)", out_valid, cos_out, sin_out);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, '0, 1'b0);
    idle(4);
    total++;
    if (cap_c.size() != 3) begin
      bad++;
      $display("FAIL post_reset_count got=%0d want=3", cap_c.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (cap_c[i] != 127 || cap_s[i] != 0) begin
          bad++;
          $display("FAIL post_reset[%0d] got=(%0d,%0d) want=(127,0)", i, cap_c[i], cap_s[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_quarter();
    test_step4();
    test_step1();
    test_gap();
    test_clr();
    test_async_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
